// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding unit: control states and forward-select codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    StRun,
    StFlush,
    StDrain,
    StHalted
  } state_e;

  localparam logic [2:0] FWD_NONE = 3'd0;
  localparam logic [2:0] FWD_EX   = 3'd1;

  localparam int unsigned StallCntW = 16;

  // Select code for a result sitting in tag entry idx (0 = EX).
  function automatic logic [2:0] fwd_code(input int idx);
    return FWD_EX + 3'(idx);
  endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// Destination-tag shift register: one entry per tracked stage after ID, entry 0 = EX.
module hazard_tag_pipe #(
  parameter int unsigned RegW   = 3,
  parameter int unsigned NStage = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_valid_i,
  input  logic [RegW-1:0]                in_rd_i,
  input  logic                           in_wr_en_i,
  input  logic                           in_is_load_i,
  output logic [NStage-1:0]              valid_o,
  output logic [NStage-1:0][RegW-1:0]    rd_o,
  output logic [NStage-1:0]              wr_en_o,
  output logic                           head_is_load_o
);

  logic [NStage-1:0]           valid_d, valid_q;
  logic [NStage-1:0][RegW-1:0] rd_d, rd_q;
  logic [NStage-1:0]           wr_en_d, wr_en_q;
  // Load-ness only matters while the producer is in EX, so only the head keeps it.
  logic                        head_is_load_d, head_is_load_q;

  always_comb begin
    valid_d        = {valid_q[NStage-2:0], in_valid_i};
    rd_d           = {rd_q[NStage-2:0], in_rd_i};
    wr_en_d        = {wr_en_q[NStage-2:0], in_wr_en_i};
    head_is_load_d = in_valid_i & in_is_load_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q        <= '0;
      rd_q           <= '0;
      wr_en_q        <= '0;
      head_is_load_q <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      rd_q           <= rd_d;
      wr_en_q        <= wr_en_d;
      head_is_load_q <= head_is_load_d;
    end
  end

  assign valid_o        = valid_q;
  assign rd_o           = rd_q;
  assign wr_en_o        = wr_en_q;
  assign head_is_load_o = head_is_load_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard detection, operand-forward selection, redirect flush and halt drain control.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W     = 3,
  parameter int unsigned NSTAGE    = 3,
  parameter int unsigned FWD_EN    = 1,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_W-1:0]     id_rs1,
  input  logic [REG_W-1:0]     id_rs2,
  input  logic                 id_rs1_en,
  input  logic                 id_rs2_en,
  input  logic [REG_W-1:0]     id_rd,
  input  logic                 id_wr_en,
  input  logic                 id_is_load,
  input  logic                 id_halt,
  input  logic                 ex_redirect,
  output logic                 stall,
  output logic                 bubble,
  output logic                 flush_ifid,
  output logic [2:0]           fwd_sel1,
  output logic [2:0]           fwd_sel2,
  output logic                 halted,
  output logic [StallCntW-1:0] stall_cnt
);

  localparam logic [1:0] FlushLoad = 2'(FLUSH_CYC - 1);
  localparam logic [2:0] DrainLoad = 3'(NSTAGE - 1);

  logic [NSTAGE-1:0]            tag_valid;
  logic [NSTAGE-1:0][REG_W-1:0] tag_rd;
  logic [NSTAGE-1:0]            tag_wr_en;
  logic                         tag_head_is_load;

  logic [NSTAGE-1:0] m1, m2;
  logic [2:0]        sel1, sel2;
  logic              load_use, hazard, issue;

  state_e                 state_d, state_q;
  logic [1:0]             flush_cnt_d, flush_cnt_q;
  logic [2:0]             drain_cnt_d, drain_cnt_q;
  logic [StallCntW-1:0]   stall_cnt_d, stall_cnt_q;

  hazard_tag_pipe #(
    .RegW   (REG_W),
    .NStage (NSTAGE)
  ) u_tag_pipe (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (issue),
    .in_rd_i        (id_rd),
    .in_wr_en_i     (id_wr_en),
    .in_is_load_i   (id_is_load),
    .valid_o        (tag_valid),
    .rd_o           (tag_rd),
    .wr_en_o        (tag_wr_en),
    .head_is_load_o (tag_head_is_load)
  );

  // Walk oldest to youngest so the youngest matching producer wins.
  always_comb begin
    m1   = '0;
    m2   = '0;
    sel1 = FWD_NONE;
    sel2 = FWD_NONE;
    for (int i = int'(NSTAGE) - 1; i >= 0; i--) begin
      m1[i] = tag_valid[i] & tag_wr_en[i] & id_rs1_en & (tag_rd[i] == id_rs1);
      m2[i] = tag_valid[i] & tag_wr_en[i] & id_rs2_en & (tag_rd[i] == id_rs2);
      if (m1[i]) sel1 = fwd_code(i);
      if (m2[i]) sel2 = fwd_code(i);
    end
  end

  always_comb begin
    load_use = id_valid & (m1[0] | m2[0]) & tag_head_is_load;
    hazard   = (FWD_EN != 0) ? load_use : (id_valid & ((|m1) | (|m2)));
    fwd_sel1 = ((FWD_EN != 0) && !load_use) ? sel1 : FWD_NONE;
    fwd_sel2 = ((FWD_EN != 0) && !load_use) ? sel2 : FWD_NONE;
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    drain_cnt_d = drain_cnt_q;
    stall       = 1'b0;
    bubble      = 1'b0;
    flush_ifid  = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      StRun: begin
        if (ex_redirect) begin
          flush_ifid = 1'b1;
          bubble     = 1'b1;
          if (FLUSH_CYC > 1) begin
            state_d     = StFlush;
            flush_cnt_d = FlushLoad;
          end
        end else begin
          stall  = hazard;
          bubble = hazard;
          if (id_valid && !hazard && id_halt) begin
            state_d     = StDrain;
            drain_cnt_d = DrainLoad;
          end
        end
      end
      StFlush: begin
        flush_ifid = 1'b1;
        bubble     = 1'b1;
        // Counter holds the FLUSH cycles still owed, including the current one.
        if (ex_redirect) begin
          flush_cnt_d = FlushLoad;
        end else if (flush_cnt_q <= 2'd1) begin
          state_d     = StRun;
          flush_cnt_d = 2'd0;
        end else begin
          flush_cnt_d = flush_cnt_q - 2'd1;
        end
      end
      StDrain: begin
        stall  = 1'b1;
        bubble = 1'b1;
        if (drain_cnt_q == 3'd0) begin
          state_d = StHalted;
        end else begin
          drain_cnt_d = drain_cnt_q - 3'd1;
        end
      end
      StHalted: begin
        stall  = 1'b1;
        bubble = 1'b1;
        halted = 1'b1;
      end
      default: state_d = StRun;
    endcase
  end

  assign issue = id_valid & ~stall & ~bubble;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (state_q != StHalted) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      flush_cnt_q <= 2'd0;
      drain_cnt_q <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scenario bench: forwarding, load-use, stall-only, flush, drain/halt and counter saturation.
module tb_hazard_fwd_unit;

  typedef struct packed {
    logic       v;
    logic [2:0] rs1;
    logic       e1;
    logic [2:0] rs2;
    logic       e2;
    logic [2:0] rd;
    logic       we;
    logic       ld;
    logic       halt;
    logic       redir;
  } stim_t;

  typedef struct packed {
    logic       stall;
    logic       bubble;
    logic       flush;
    logic [2:0] sel1;
    logic [2:0] sel2;
    logic       halted;
  } obs_t;

  logic       clk, rst;
  logic       id_valid, id_rs1_en, id_rs2_en, id_wr_en, id_is_load, id_halt, ex_redirect;
  logic [2:0] id_rs1, id_rs2, id_rd;

  logic        stall_a, bubble_a, flush_a, halted_a;
  logic [2:0]  sel1_a, sel2_a;
  logic [15:0] cnt_a;
  logic        stall_b, bubble_b, flush_b, halted_b;
  logic [2:0]  sel1_b, sel2_b;
  logic [15:0] cnt_b;
  logic        stall_c, bubble_c, flush_c, halted_c;
  logic [2:0]  sel1_c, sel2_c;
  logic [15:0] cnt_c;

  obs_t obs_a, obs_b, obs_c;
  assign obs_a = {stall_a, bubble_a, flush_a, sel1_a, sel2_a, halted_a};
  assign obs_b = {stall_b, bubble_b, flush_b, sel1_b, sel2_b, halted_b};
  assign obs_c = {stall_c, bubble_c, flush_c, sel1_c, sel2_c, halted_c};

  int total = 0;
  int bad   = 0;
  obs_t exp_q[$];

  // A: forwarding, B: stall-only, C: stall-only deep pipe with single-cycle flush.
  hazard_fwd_unit #(.REG_W(3), .NSTAGE(3), .FWD_EN(1), .FLUSH_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .id_halt(id_halt), .ex_redirect(ex_redirect),
    .stall(stall_a), .bubble(bubble_a), .flush_ifid(flush_a), .fwd_sel1(sel1_a),
    .fwd_sel2(sel2_a), .halted(halted_a), .stall_cnt(cnt_a)
  );

  hazard_fwd_unit #(.REG_W(3), .NSTAGE(3), .FWD_EN(0), .FLUSH_CYC(2)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .id_halt(id_halt), .ex_redirect(ex_redirect),
    .stall(stall_b), .bubble(bubble_b), .flush_ifid(flush_b), .fwd_sel1(sel1_b),
    .fwd_sel2(sel2_b), .halted(halted_b), .stall_cnt(cnt_b)
  );

  hazard_fwd_unit #(.REG_W(3), .NSTAGE(6), .FWD_EN(0), .FLUSH_CYC(1)) dut_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .id_halt(id_halt), .ex_redirect(ex_redirect),
    .stall(stall_c), .bubble(bubble_c), .flush_ifid(flush_c), .fwd_sel1(sel1_c),
    .fwd_sel2(sel2_c), .halted(halted_c), .stall_cnt(cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(logic v, logic [2:0] rs1, logic e1, logic [2:0] rs2, logic e2,
                               logic [2:0] rd, logic we, logic ld, logic halt, logic redir);
    return {v, rs1, e1, rs2, e2, rd, we, ld, halt, redir};
  endfunction

  function automatic obs_t ob(logic st, logic bu, logic fl, logic [2:0] s1, logic [2:0] s2,
                              logic ha);
    return {st, bu, fl, s1, s2, ha};
  endfunction

  task automatic apply(input stim_t s);
    {id_valid, id_rs1, id_rs1_en, id_rs2, id_rs2_en, id_rd, id_wr_en, id_is_load, id_halt,
     ex_redirect} = s;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply('0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply('0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    apply(mk(1, 3'd0, 1, 3'd0, 1, 3'd0, 0, 0, 0, 0));
    @(negedge clk);
    total += 6;
    if (obs_a !== '0) begin bad++; $display("FAIL reset_obs_a got=%h want=0", obs_a); end
    if (obs_b !== '0) begin bad++; $display("FAIL reset_obs_b got=%h want=0", obs_b); end
    if (obs_c !== '0) begin bad++; $display("FAIL reset_obs_c got=%h want=0", obs_c); end
    if (cnt_a !== 16'd0) begin bad++; $display("FAIL reset_cnt_a got=%0d want=0", cnt_a); end
    if (cnt_b !== 16'd0) begin bad++; $display("FAIL reset_cnt_b got=%0d want=0", cnt_b); end
    if (cnt_c !== 16'd0) begin bad++; $display("FAIL reset_cnt_c got=%0d want=0", cnt_c); end
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    stim_t st[10];
    obs_t  ex[10];
    obs_t  want;
    do_reset();
    st[0] = mk(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0, 0, 0); ex[0] = ob(0, 0, 0, 3'd0, 3'd0, 0);
    st[1] = mk(1, 3'd3, 1, 3'd0, 0, 3'd4, 1, 0, 0, 0); ex[1] = ob(0, 0, 0, 3'd1, 3'd0, 0);
    st[2] = mk(1, 3'd3, 1, 3'd4, 1, 3'd0, 0, 0, 0, 0); ex[2] = ob(0, 0, 0, 3'd2, 3'd1, 0);
    st[3] = mk(1, 3'd3, 1, 3'd4, 1, 3'd0, 0, 0, 0, 0); ex[3] = ob(0, 0, 0, 3'd3, 3'd2, 0);
    st[4] = mk(1, 3'd3, 1, 3'd4, 1, 3'd0, 0, 0, 0, 0); ex[4] = ob(0, 0, 0, 3'd0, 3'd3, 0);
    st[5] = mk(1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 0, 0, 0); ex[5] = ob(0, 0, 0, 3'd0, 3'd0, 0);
    st[6] = mk(1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 0, 0, 0); ex[6] = ob(0, 0, 0, 3'd0, 3'd0, 0);
    st[7] = mk(1, 3'd6, 0, 3'd6, 1, 3'd7, 0, 0, 0, 0); ex[7] = ob(0, 0, 0, 3'd0, 3'd1, 0);
    st[8] = mk(1, 3'd7, 1, 3'd0, 0, 3'd0, 0, 0, 0, 0); ex[8] = ob(0, 0, 0, 3'd0, 3'd0, 0);
    st[9] = mk(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0); ex[9] = ob(0, 0, 0, 3'd0, 3'd0, 0);
    for (int i = 0; i < 10; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      total++;
      if (obs_a !== want) begin
        bad++;
        $display("FAIL forward[%0d] got=%h want=%h", i, obs_a, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t st[5];
    obs_t  ex[5];
    obs_t  want;
    do_reset();
    st[0] = mk(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0, 0); ex[0] = ob(0, 0, 0, 3'd0, 3'd0, 0);
    st[1] = mk(1, 3'd0, 0, 3'd2, 1, 3'd5, 1, 0, 0, 0); ex[1] = ob(1, 1, 0, 3'd0, 3'd0, 0);
    st[2] = mk(1, 3'd0, 0, 3'd2, 1, 3'd5, 1, 0, 0, 0); ex[2] = ob(0, 0, 0, 3'd0, 3'd2, 0);
    st[3] = mk(1, 3'd5, 1, 3'd2, 1, 3'd0, 0, 0, 0, 0); ex[3] = ob(0, 0, 0, 3'd1, 3'd3, 0);
    st[4] = mk(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0); ex[4] = ob(0, 0, 0, 3'd0, 3'd0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      total++;
      if (obs_a !== want) begin
        bad++;
        $display("FAIL load_use[%0d] got=%h want=%h", i, obs_a, want);
      end
      @(posedge clk); #1;
    end
    total++;
    if (cnt_a !== 16'd1) begin bad++; $display("FAIL load_use_cnt got=%0d want=1", cnt_a); end
  endtask

  task automatic test_stall_only();
    stim_t st[6];
    obs_t  ex[6];
    obs_t  want;
    do_reset();
    st[0] = mk(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 0, 0, 0); ex[0] = ob(0, 0, 0, 3'd0, 3'd0, 0);
    st[1] = mk(1, 3'd5, 1, 3'd0, 0, 3'd1, 1, 0, 0, 0); ex[1] = ob(1, 1, 0, 3'd0, 3'd0, 0);
    st[2] = st[1];                                      ex[2] = ob(1, 1, 0, 3'd0, 3'd0, 0);
    st[3] = st[1];                                      ex[3] = ob(1, 1, 0, 3'd0, 3'd0, 0);
    st[4] = st[1];                                      ex[4] = ob(0, 0, 0, 3'd0, 3'd0, 0);
    st[5] = mk(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0); ex[5] = ob(0, 0, 0, 3'd0, 3'd0, 0);
    for (int i = 0; i < 6; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      total++;
      if (obs_b !== want) begin
        bad++;
        $display("FAIL stall_only[%0d] got=%h want=%h", i, obs_b, want);
      end
      @(posedge clk); #1;
    end
    total++;
    if (cnt_b !== 16'd3) begin bad++; $display("FAIL stall_only_cnt got=%0d want=3", cnt_b); end
  endtask

  task automatic test_flush();
    stim_t st[15];
    obs_t  ex[15];
    stim_t sc[4];
    obs_t  ec[4];
    obs_t  want;
    stim_t idle, plain;
    idle  = mk(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0);
    plain = mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0);
    do_reset();
    st[0]  = mk(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 0, 0, 1); ex[0]  = ob(0, 1, 1, 3'd0, 3'd0, 0);
    st[1]  = mk(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 0, 0, 0); ex[1]  = ob(0, 1, 1, 3'd0, 3'd0, 0);
    st[2]  = st[1];                                      ex[2]  = ob(0, 0, 0, 3'd0, 3'd0, 0);
    st[3]  = mk(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0, 0); ex[3]  = ob(0, 0, 0, 3'd0, 3'd0, 0);
    st[4]  = mk(1, 3'd0, 0, 3'd2, 1, 3'd0, 0, 0, 0, 1); ex[4]  = ob(0, 1, 1, 3'd0, 3'd0, 0);
    st[5]  = mk(1, 3'd0, 0, 3'd2, 0, 3'd0, 0, 0, 0, 0); ex[5]  = ob(0, 1, 1, 3'd0, 3'd0, 0);
    st[6]  = plain;                                      ex[6]  = ob(0, 0, 0, 3'd0, 3'd0, 0);
    st[7]  = mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1); ex[7]  = ob(0, 1, 1, 3'd0, 3'd0, 0);
    st[8]  = idle;                                       ex[8]  = ob(0, 1, 1, 3'd0, 3'd0, 0);
    st[9]  = plain;                                      ex[9]  = ob(0, 0, 0, 3'd0, 3'd0, 0);
    st[10] = idle;                                       ex[10] = ob(0, 0, 0, 3'd0, 3'd0, 0);
    st[11] = mk(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 1); ex[11] = ob(0, 1, 1, 3'd0, 3'd0, 0);
    st[12] = st[11];                                     ex[12] = ob(0, 1, 1, 3'd0, 3'd0, 0);
    st[13] = idle;                                       ex[13] = ob(0, 1, 1, 3'd0, 3'd0, 0);
    st[14] = idle;                                       ex[14] = ob(0, 0, 0, 3'd0, 3'd0, 0);
    for (int i = 0; i < 15; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      total++;
      if (obs_a !== want) begin
        bad++;
        $display("FAIL flush[%0d] got=%h want=%h", i, obs_a, want);
      end
      @(posedge clk); #1;
    end
    // Single-cycle flush configuration never leaves RUN.
    do_reset();
    sc[0] = mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 1); ec[0] = ob(0, 1, 1, 3'd0, 3'd0, 0);
    sc[1] = plain;                                      ec[1] = ob(0, 0, 0, 3'd0, 3'd0, 0);
    sc[2] = mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1); ec[2] = ob(0, 1, 1, 3'd0, 3'd0, 0);
    sc[3] = plain;                                      ec[3] = ob(0, 0, 0, 3'd0, 3'd0, 0);
    for (int i = 0; i < 4; i++) begin
      apply(sc[i]);
      exp_q.push_back(ec[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      total++;
      if (obs_c !== want) begin
        bad++;
        $display("FAIL flush1[%0d] got=%h want=%h", i, obs_c, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_drain();
    stim_t st[6];
    obs_t  ex[6];
    obs_t  want;
    do_reset();
    st[0] = mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1, 0); ex[0] = ob(0, 0, 0, 3'd0, 3'd0, 0);
    st[1] = mk(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 1); ex[1] = ob(1, 1, 0, 3'd0, 3'd0, 0);
    st[2] = mk(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0); ex[2] = ob(1, 1, 0, 3'd0, 3'd0, 0);
    st[3] = st[2];                                      ex[3] = ob(1, 1, 0, 3'd0, 3'd0, 0);
    st[4] = st[1];                                      ex[4] = ob(1, 1, 0, 3'd0, 3'd0, 1);
    st[5] = mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0); ex[5] = ob(1, 1, 0, 3'd0, 3'd0, 1);
    for (int i = 0; i < 6; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      total++;
      if (obs_a !== want) begin
        bad++;
        $display("FAIL drain[%0d] got=%h want=%h", i, obs_a, want);
      end
      @(posedge clk); #1;
    end
    total++;
    if (cnt_a !== 16'd3) begin bad++; $display("FAIL drain_cnt got=%0d want=3", cnt_a); end
  endtask

  task automatic test_reset_in_drain();
    obs_t want;
    do_reset();
    apply(mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1, 0));
    @(posedge clk); #1;
    apply('0);
    exp_q.push_back(ob(1, 1, 0, 3'd0, 3'd0, 0));
    @(negedge clk);
    want = exp_q.pop_front();
    total++;
    if (obs_a !== want) begin bad++; $display("FAIL rst_drain_pre got=%h want=%h", obs_a, want); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    apply(mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0));
    exp_q.push_back(ob(0, 0, 0, 3'd0, 3'd0, 0));
    @(negedge clk);
    want = exp_q.pop_front();
    total += 2;
    if (obs_a !== want) begin bad++; $display("FAIL rst_drain_post got=%h want=%h", obs_a, want); end
    if (cnt_a !== 16'd0) begin bad++; $display("FAIL rst_drain_cnt got=%0d want=0", cnt_a); end
    @(posedge clk); #1;
    apply('0);
    @(negedge clk);
    total++;
    if (obs_a !== '0) begin bad++; $display("FAIL rst_drain_idle got=%h want=0", obs_a); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    do_reset();
    // Self-dependent write: one issue then NSTAGE=6 stall cycles, repeating.
    apply(mk(1, 3'd5, 1, 3'd0, 0, 3'd5, 1, 0, 0, 0));
    repeat (14) @(posedge clk);
    #1;
    total++;
    if (cnt_c !== 16'd12) begin bad++; $display("FAIL sat_early got=%0d want=12", cnt_c); end
    repeat (77000) @(posedge clk);
    #1;
    total++;
    if (cnt_c !== 16'hFFFF) begin bad++; $display("FAIL sat_cnt got=%h want=ffff", cnt_c); end
    apply('0);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_stall_only();
    test_flush();
    test_drain();
    test_reset_in_drain();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
